// File: rtl/bdd_pkg.sv
// Shared constants and types for the decision-tree walk controller.
// Node and child word layouts, FSM state encoding and datapath widths.
package bdd_pkg;

    localparam int NODE_WIDTH  = 48;
    localparam int CHILD_WIDTH = 18;
    localparam int ACC_WIDTH   = 19;
    localparam int PROD_WIDTH  = 16;

    // Coefficient word: c1 in the top byte, threshold in the bottom byte.
    localparam int C1_MSB  = 47;
    localparam int C1_LSB  = 40;
    localparam int C2_MSB  = 39;
    localparam int C2_LSB  = 32;
    localparam int C3_MSB  = 31;
    localparam int C3_LSB  = 24;
    localparam int C4_MSB  = 23;
    localparam int C4_LSB  = 16;
    localparam int C5_MSB  = 15;
    localparam int C5_LSB  = 8;
    localparam int THR_MSB = 7;
    localparam int THR_LSB = 0;

    // Child word: two 9-bit entries, each {leaf, class/addr}.
    localparam int LEFT_MSB  = 17;
    localparam int LEFT_LSB  = 9;
    localparam int RIGHT_MSB = 8;
    localparam int RIGHT_LSB = 0;
    localparam int LEAF_BIT  = 8;
    localparam int ADDR_MSB  = 5;
    localparam int ADDR_LSB  = 0;
    localparam int CLASS_MSB = 7;
    localparam int CLASS_LSB = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        MAC    = 3'd3,
        DECIDE = 3'd4,
        RESULT = 3'd5
    } state_t;

endpackage

// File: rtl/bdd_serial_mac.sv
// Time-shared multiply-accumulate: one 8x8 product per enabled cycle,
// term selected by idx (0 = a1*c1 .. 4 = a5*c5).
module bdd_serial_mac
    import bdd_pkg::*;
#(
    parameter int FEAT_WIDTH = 8,
    parameter int NUM_FEAT   = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic [2:0]                     idx,
    input  logic [NUM_FEAT*FEAT_WIDTH-1:0] feat,
    input  logic [NUM_FEAT*FEAT_WIDTH-1:0] coef,
    output logic [ACC_WIDTH-1:0]           acc
);

    logic [FEAT_WIDTH-1:0] a_sel;
    logic [FEAT_WIDTH-1:0] c_sel;
    logic [PROD_WIDTH-1:0] prod;

    // Term 0 lives in the most significant slot of both packed vectors.
    always_comb begin
        a_sel = '0;
        c_sel = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            if (idx == 3'(i)) begin
                a_sel = feat[(NUM_FEAT-1-i)*FEAT_WIDTH +: FEAT_WIDTH];
                c_sel = coef[(NUM_FEAT-1-i)*FEAT_WIDTH +: FEAT_WIDTH];
            end
        end
    end

    assign prod = PROD_WIDTH'(a_sel) * PROD_WIDTH'(c_sel);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/bdd_walk_ctrl.sv
// Decision-tree walk controller: accepts one feature vector, walks the node
// SRAMs one node per 8 cycles and returns the leaf class over valid/ready.
module bdd_walk_ctrl
    import bdd_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int FEAT_WIDTH = 8,
    parameter int NUM_FEAT   = 5,
    parameter int MAX_DEPTH  = 16,
    parameter int ROOT_ADDR  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_FEAT*FEAT_WIDTH-1:0] in_feat,
    output logic [ADDR_WIDTH-1:0]          node_addr,
    output logic                           node_rd,
    input  logic [NODE_WIDTH-1:0]          node_data,
    input  logic [CHILD_WIDTH-1:0]         child_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_class,
    output logic                           out_err,
    output logic                           busy,
    output state_t                         state_dbg
);

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid and payload hold until then.

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    state_t state, state_nxt;

    logic [NUM_FEAT*FEAT_WIDTH-1:0] feat_q;
    logic [NODE_WIDTH-1:0]          node_q;
    logic [CHILD_WIDTH-1:0]         child_q;
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [DEPTH_W-1:0]             depth_q;
    logic [DEPTH_W-1:0]             depth_nxt;
    logic [2:0]                     k_q;
    logic [ACC_WIDTH-1:0]           acc;
    logic [ACC_WIDTH-1:0]           threshold;
    logic [8:0]                     sel;
    logic                           sel_leaf;
    logic                           sel_bad_addr;
    logic                           depth_fault;
    logic                           mac_clr;
    logic                           mac_en;

    bdd_serial_mac #(
        .FEAT_WIDTH(FEAT_WIDTH),
        .NUM_FEAT  (NUM_FEAT)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .idx (k_q),
        .feat(feat_q),
        .coef(node_q[C1_MSB:C5_LSB]),
        .acc (acc)
    );

    // Threshold is compared in the product's scale: thr occupies bits [15:8].
    assign threshold    = ACC_WIDTH'(node_q[THR_MSB:THR_LSB]) << 8;
    assign sel          = (acc < threshold) ? child_q[LEFT_MSB:LEFT_LSB]
                                            : child_q[RIGHT_MSB:RIGHT_LSB];
    assign sel_leaf     = sel[LEAF_BIT];
    assign sel_bad_addr = |sel[CLASS_MSB:ADDR_WIDTH];
    assign depth_nxt    = depth_q + 1'b1;
    assign depth_fault  = (depth_nxt == DEPTH_W'(MAX_DEPTH));

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == RESULT);
    assign node_rd   = (state == FETCH);
    assign node_addr = addr_q;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state)
            IDLE:   if (in_valid) state_nxt = FETCH;
            FETCH:  state_nxt = WAIT;
            WAIT: begin
                mac_clr   = 1'b1;
                state_nxt = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (k_q == 3'(NUM_FEAT - 1)) state_nxt = DECIDE;
            end
            DECIDE: begin
                if (sel_leaf || sel_bad_addr || depth_fault) state_nxt = RESULT;
                else                                         state_nxt = FETCH;
            end
            RESULT: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feat_q    <= '0;
            node_q    <= '0;
            child_q   <= '0;
            addr_q    <= '0;
            depth_q   <= '0;
            k_q       <= '0;
            out_class <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat_q  <= in_feat;
                        addr_q  <= ADDR_WIDTH'(ROOT_ADDR);
                        depth_q <= '0;
                    end
                end
                WAIT: begin
                    node_q  <= node_data;
                    child_q <= child_data;
                    k_q     <= '0;
                end
                MAC: k_q <= k_q + 3'd1;
                DECIDE: begin
                    if (sel_leaf) begin
                        out_class <= sel[CLASS_MSB:CLASS_LSB];
                        out_err   <= 1'b0;
                    end else if (sel_bad_addr || depth_fault) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                    end else begin
                        addr_q  <= sel[ADDR_MSB:ADDR_LSB];
                        depth_q <= depth_nxt;
                    end
                end
                RESULT: if (out_ready) out_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bdd_walk_ctrl.sv
// Directed bench for bdd_walk_ctrl with behavioural 1-cycle-latency node SRAMs.
module tb_bdd_walk_ctrl;
    import bdd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [39:0] in_feat = '0;
    logic [5:0]  node_addr;
    logic        node_rd;
    logic [47:0] node_data = '0;
    logic [17:0] child_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_class;
    logic        out_err;
    logic        busy;
    state_t      state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] coef_mem [64];
    logic [17:0] child_mem[64];
    logic [5:0]  addr_log[$];
    logic [5:0]  exp_q[$];

    bdd_walk_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .node_addr (node_addr),
        .node_rd   (node_rd),
        .node_data (node_data),
        .child_data(child_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / SRAM model / read monitor
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (node_rd) begin
            node_data  <= coef_mem[node_addr];
            child_data <= child_mem[node_addr];
        end
    end

    always @(negedge clk) begin
        if (node_rd) addr_log.push_back(node_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mk_node(input logic [7:0] c, input logic [7:0] thr);
        return {c, c, c, c, c, thr};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            coef_mem[i]  = '0;
            child_mem[i] = {9'h1FF, 9'h1FF};
        end
    endtask

    // Offers one sample; returns the cycle (handshake = 0) of the first out_valid.
    task automatic send(input logic [39:0] f, input bit ack, output int lat);
        addr_log.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_feat  = f;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) begin
            check("result_timeout", 32'(lat), 32'd0);
        end else if (ack) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bit stall_ok;
        logic [7:0] held_class;
        logic       held_err;

        clear_mem();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_node_rd", 32'(node_rd), 32'd0);
        check("rst_node_addr", 32'(node_addr), 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // single node, t=50 < 256 -> left leaf class 7
        coef_mem[0]  = mk_node(8'd1, 8'd1);
        child_mem[0] = {9'h107, 9'h1FF};
        send({5{8'd10}}, 1'b1, lat);
        check("single_lat", 32'(lat), 32'd9);
        check("single_class", 32'(out_class), 32'd7);
        check("single_err", 32'(out_err), 32'd0);
        check("single_rd_count", 32'(addr_log.size()), 32'd1);

        // t=325125 >= 65280 -> right leaf class 3
        coef_mem[0]  = mk_node(8'd255, 8'd255);
        child_mem[0] = {9'h1AA, 9'h103};
        send({5{8'd255}}, 1'b1, lat);
        check("above_lat", 32'(lat), 32'd9);
        check("above_class", 32'(out_class), 32'd3);

        // t = 16*16 = 256 = thr<<8 exactly -> right
        coef_mem[0]  = {8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        child_mem[0] = {9'h111, 9'h122};
        send({8'd16, 32'd0}, 1'b1, lat);
        check("equal_class", 32'(out_class), 32'h22);

        // t = 15*16 = 240, one step below -> left
        send({8'd15, 32'd0}, 1'b1, lat);
        check("below_class", 32'(out_class), 32'h11);

        // depth-3 path 0 -> 5 -> 12 -> leaf 0x2A (acc=0 < 256 always picks left)
        clear_mem();
        coef_mem[0]   = mk_node(8'd0, 8'd1);
        coef_mem[5]   = mk_node(8'd0, 8'd1);
        coef_mem[12]  = mk_node(8'd0, 8'd1);
        child_mem[0]  = {9'h005, 9'h1EE};
        child_mem[5]  = {9'h00C, 9'h1EE};
        child_mem[12] = {9'h12A, 9'h1EE};
        exp_q = '{6'd0, 6'd5, 6'd12};
        send({5{8'd3}}, 1'b1, lat);
        check("depth3_lat", 32'(lat), 32'd25);
        check("depth3_class", 32'(out_class), 32'h2A);
        check("depth3_rd_count", 32'(addr_log.size()), 32'd3);
        while (exp_q.size() > 0 && addr_log.size() > 0) begin
            check("depth3_addr", 32'(addr_log.pop_front()), 32'(exp_q.pop_front()));
        end

        // self-loop on node 0 -> depth fault after 16 nodes
        clear_mem();
        coef_mem[0]  = mk_node(8'd0, 8'd1);
        child_mem[0] = {9'h000, 9'h000};
        send({5{8'd1}}, 1'b1, lat);
        check("loop_lat", 32'(lat), 32'd129);
        check("loop_rd_count", 32'(addr_log.size()), 32'd16);

        // Re-run to observe the fault outputs before acknowledging.
        send({5{8'd1}}, 1'b0, lat);
        check("loop_err", 32'(out_err), 32'd1);
        check("loop_class", 32'(out_class), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // out-of-range child 9'h0C0 -> error after one node, then stall
        child_mem[0] = {9'h0C0, 9'h0C0};
        send({5{8'd1}}, 1'b0, lat);
        check("badaddr_lat", 32'(lat), 32'd9);
        check("badaddr_err", 32'(out_err), 32'd1);
        check("badaddr_class", 32'(out_class), 32'd0);
        held_class = out_class;
        held_err   = out_err;
        stall_ok   = 1'b1;
        in_valid   = 1'b1;
        in_feat    = {5{8'd10}};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_class !== held_class || out_err !== held_err || in_ready)
                stall_ok = 1'b0;
        end
        check("stall_hold", 32'(stall_ok), 32'd1);
        coef_mem[0]  = mk_node(8'd1, 8'd1);
        child_mem[0] = {9'h107, 9'h1FF};
        out_ready = 1'b1;
        check("ack_cycle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("post_ack_in_ready", 32'(in_ready), 32'd1);
        check("post_ack_out_valid", 32'(out_valid), 32'd0);
        check("post_ack_err", 32'(out_err), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("post_ack_accepted", 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        check("post_ack_lat", 32'(lat), 32'd9);
        check("post_ack_class", 32'(out_class), 32'd7);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // reset asserted during MAC
        @(negedge clk);
        in_valid = 1'b1;
        in_feat  = {5{8'd10}};
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_state", 32'(state_dbg), 32'(MAC));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_node_rd", 32'(node_rd), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        send({5{8'd10}}, 1'b1, lat);
        check("after_rst_lat", 32'(lat), 32'd9);
        check("after_rst_class", 32'(out_class), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bdd_walk_ctrl.md
# bdd_walk_ctrl

Sequencing controller for the BDD/decision-tree inference datapath. It accepts one feature vector (a1..a5) per request and walks the tree stored in the two node SRAMs: the 48-bit coefficient SRAM and the 18-bit child SRAM, sharing one address. At each node it evaluates the weighted sum with a single time-shared multiplier, selects a child, and stops at a leaf. The leaf class is returned over a valid/ready result port.

## Interface
Parameters:
- ADDR_WIDTH, 6: node SRAM address width (64 nodes).
- FEAT_WIDTH, 8: feature and coefficient width.
- NUM_FEAT, 5: features per sample.
- MAX_DEPTH, 16: maximum nodes visited before an error is reported.
- ROOT_ADDR, 0: address of the root node.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  feature vector offered.
- in_ready  out  1  controller can accept a sample.
- in_feat  in  40  packed features: a1=[39:32], a2=[31:24], a3=[23:16], a4=[15:8], a5=[7:0].
- node_addr  out  ADDR_WIDTH  shared read address to both SRAMs.
- node_rd  out  1  read strobe to both SRAMs.
- node_data  in  48  coefficient word: c1=[47:40], c2=[39:32], c3=[31:24], c4=[23:16], c5=[15:8], thr=[7:0].
- child_data  in  18  child word: left=[17:9], right=[8:0].
- out_valid  out  1  result available.
- out_ready  in  1  result consumer ready.
- out_class  out  8  leaf class.
- out_err  out  1  traversal fault; out_class is 0 when set.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset forces state IDLE with in_ready=1 and busy=0. It clears out_valid, out_class, out_err, node_rd, node_addr, the depth counter and the accumulator.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_feat, set addr=ROOT_ADDR, depth=0, go to FETCH.
  - FETCH: node_rd=1 and node_addr=addr. Go to WAIT.
  - WAIT: the SRAMs have 1-cycle read latency. Latch node_data and child_data into local registers, clear the accumulator, go to MAC.
  - MAC: 5 cycles, k=1..5. Each cycle does acc += a_k*c_k (8x8 unsigned product, 16 bits). Go to DECIDE.
  - DECIDE: compute depth+1 and select a child, then take the first matching exit:
    - Child selection: t = acc (19 bits unsigned, no overflow possible); threshold = {3'b0, thr, 8'b0}. t < threshold selects left; t >= threshold (equality included) selects right.
    - Exit 1: child bit8=1 means leaf. out_class = child[7:0], go to RESULT.
    - Exit 2: child bit8=0 and child[7:6]≠0 means an out-of-range address. out_err=1, go to RESULT.
    - Exit 3: child bit8=0 and depth+1 = MAX_DEPTH means a depth fault. out_err=1, go to RESULT.
    - Otherwise: addr = child[5:0], depth = depth+1, go to FETCH.
  - RESULT: out_valid=1. out_class and out_err are held stable until out_valid && out_ready. On that handshake, clear out_valid and out_err and go to IDLE.
- Only one sample is in flight. in_ready=0 in all states except IDLE.
- The controller never writes the SRAMs. Write ports are tied off at the top level.

## Timing
- Each node visited costs 8 cycles: FETCH 1, WAIT 1, MAC 5, DECIDE 1.
- Input handshake in cycle 0 (IDLE). For d nodes visited, out_valid first goes high in cycle 8·d+1.
- node_rd is asserted for exactly one cycle per node. node_addr is stable during FETCH.
- in_ready is high in the handshake-complete cycle only if the state is IDLE. A new sample is accepted at the earliest in the cycle after the output handshake.
- out_valid=1 with out_ready=0 stalls indefinitely. Outputs are held with no timeout.
- rst asserted in any state takes effect at the next edge: the cycle after, the state is IDLE and the in-flight sample is discarded. rst takes priority over simultaneous in_valid or out_ready.

## Structure
- Shared package bdd_pkg holds:
  - the node word field offsets (C1_MSB..THR_LSB);
  - the child word layout (LEAF_BIT=8, ADDR field [5:0], CLASS field [7:0]);
  - the state enum (IDLE, FETCH, WAIT, MAC, DECIDE, RESULT);
  - the width constants ACC_WIDTH=19 and PROD_WIDTH=16.
- Sub-module bdd_serial_mac: one 8x8 multiplier and a 19-bit accumulator, with clear, enable and a 3-bit term index. It is instantiated once.
- The SRAMs stay outside this block, in the top-level instances.

## Test plan
- Single-node tree: root c1..c5=1, thr=1, left=9'h107; features all 10, so t=50 < 256. Required: out_class=7, out_err=0, out_valid in cycle 9.
- Equal and above threshold: features all 255, c1..c5=255, thr=255, so t=325125 ≥ 65280. right=9'h103 gives out_class=3. A second run with t exactly equal to the threshold must also take the right branch.
- Depth-3 path: root→node 5→node 12→leaf class 0x2A. Required: node_addr sequence 0,5,12; out_valid in cycle 25.
- Self-loop: node 0 points to itself with non-leaf children. Required: out_err=1 and out_class=0 in cycle 129, with MAX_DEPTH=16.
- Bad address: selected child = 9'h0C0. Required: out_err=1 after one node (cycle 9). Separately, out_ready held low 10 cycles: outputs stable, in_ready=0, and a new sample is accepted the cycle after the handshake.
- Reset during MAC: the next cycle shows in_ready=1, out_valid=0, node_rd=0, busy=0. A following sample then completes with correct latency.
